// File: rtl/branch_predictor.sv
// Fetch-stage direct-mapped branch predictor: 2-bit counters, tags and targets,
// trained from ID-stage resolutions, with a registered flush/redirect and saturating stats.
module branch_predictor #(
  parameter int unsigned INDEX_BITS = 6,
  parameter int unsigned STAT_BITS  = 16
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic [31:0]          FetchPC,
  output logic                 PredTaken,
  output logic [31:0]          PredTarget,
  input  logic                 ResolveValid,
  input  logic                 ResolveTaken,
  input  logic [31:0]          ResolvePC,
  input  logic [31:0]          ResolveTarget,
  input  logic                 ResolvePredTaken,
  input  logic [31:0]          ResolvePredTarget,
  output logic                 Flush,
  output logic [31:0]          RedirectPC,
  output logic [STAT_BITS-1:0] BranchCount,
  output logic [STAT_BITS-1:0] MispredictCount
);

  localparam int unsigned ENTRIES = 1 << INDEX_BITS;
  localparam int unsigned TAG_W   = 30 - INDEX_BITS;

  logic [1:0]       cnt_q [ENTRIES];
  logic [1:0]       cnt_d [ENTRIES];
  logic [TAG_W-1:0] tag_q [ENTRIES];
  logic [TAG_W-1:0] tag_d [ENTRIES];
  logic [31:0]      tgt_q [ENTRIES];
  logic [31:0]      tgt_d [ENTRIES];
  logic [ENTRIES-1:0] vld_q, vld_d;

  logic                 flush_q, flush_d;
  logic [31:0]          redirect_q, redirect_d;
  logic [STAT_BITS-1:0] br_cnt_q, br_cnt_d;
  logic [STAT_BITS-1:0] mis_cnt_q, mis_cnt_d;

  logic [INDEX_BITS-1:0] f_idx, r_idx;
  logic [TAG_W-1:0]      f_tag, r_tag;
  logic                  f_hit, r_hit, mis;
  logic                  unused_fetch_pc_bits;

  assign unused_fetch_pc_bits = ^FetchPC[1:0];

  // Lookup reads only registered state, so a same-cycle update is never visible here.
  always_comb begin
    f_idx      = FetchPC[INDEX_BITS+1:2];
    f_tag      = FetchPC[31:INDEX_BITS+2];
    f_hit      = vld_q[f_idx] && (tag_q[f_idx] == f_tag);
    PredTaken  = f_hit && cnt_q[f_idx][1];
    PredTarget = f_hit ? tgt_q[f_idx] : '0;
  end

  always_comb begin
    r_idx = ResolvePC[INDEX_BITS+1:2];
    r_tag = ResolvePC[31:INDEX_BITS+2];
    r_hit = vld_q[r_idx] && (tag_q[r_idx] == r_tag);
    mis   = ResolveValid &&
            ((ResolveTaken != ResolvePredTaken) ||
             (ResolveTaken && ResolvePredTaken && (ResolveTarget != ResolvePredTarget)));
  end

  always_comb begin
    cnt_d = cnt_q;
    tag_d = tag_q;
    tgt_d = tgt_q;
    vld_d = vld_q;
    if (ResolveValid) begin
      if (ResolveTaken) begin
        // Replacing a live entry of another tag restarts it at weakly taken.
        if (!r_hit && vld_q[r_idx]) begin
          cnt_d[r_idx] = 2'b10;
        end else if (cnt_q[r_idx] != 2'b11) begin
          cnt_d[r_idx] = cnt_q[r_idx] + 2'd1;
        end
        tag_d[r_idx] = r_tag;
        tgt_d[r_idx] = ResolveTarget;
        vld_d[r_idx] = 1'b1;
      end else if (r_hit && (cnt_q[r_idx] != 2'b00)) begin
        cnt_d[r_idx] = cnt_q[r_idx] - 2'd1;
      end
    end
  end

  always_comb begin
    flush_d    = mis;
    redirect_d = redirect_q;
    if (mis) begin
      redirect_d = ResolveTaken ? ResolveTarget : (ResolvePC + 32'd4);
    end
    br_cnt_d  = br_cnt_q;
    mis_cnt_d = mis_cnt_q;
    if (ResolveValid && (br_cnt_q != '1)) begin
      br_cnt_d = br_cnt_q + STAT_BITS'(1);
    end
    if (mis && (mis_cnt_q != '1)) begin
      mis_cnt_d = mis_cnt_q + STAT_BITS'(1);
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cnt_q      <= '{default: 2'b01};
      tag_q      <= '{default: '0};
      tgt_q      <= '{default: '0};
      vld_q      <= '0;
      flush_q    <= 1'b0;
      redirect_q <= '0;
      br_cnt_q   <= '0;
      mis_cnt_q  <= '0;
    end else begin
      cnt_q      <= cnt_d;
      tag_q      <= tag_d;
      tgt_q      <= tgt_d;
      vld_q      <= vld_d;
      flush_q    <= flush_d;
      redirect_q <= redirect_d;
      br_cnt_q   <= br_cnt_d;
      mis_cnt_q  <= mis_cnt_d;
    end
  end

  assign Flush           = flush_q;
  assign RedirectPC      = redirect_q;
  assign BranchCount     = br_cnt_q;
  assign MispredictCount = mis_cnt_q;

endmodule
